// File: rtl/mul_hilo_ctrl.sv
// HI/LO owner and sequencer for an external 32x32 combinational array multiplier.
// Handles MIPS MULT/MULTU sign fix-up, MTHI/MTLO writes, and MFHI/MFLO read stalls.
module mul_hilo_ctrl #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               op_valid,
  input  logic [2:0]         op_code,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic               op_ready,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  input  logic [2*WIDTH-1:0] mul_product,
  input  logic               rd_req,
  input  logic               rd_sel,
  output logic [WIDTH-1:0]   rd_data,
  output logic               stall,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [2:0] OP_MULTU = 3'b000;
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MTHI  = 3'b010;
  localparam logic [2:0] OP_MTLO  = 3'b011;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_neg;
  logic             r_done;
  logic [WIDTH-1:0] r_mul_a;
  logic [WIDTH-1:0] r_mul_b;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [PW-1:0]    w_result;

  // Negating the most negative value yields itself, which reads correctly as unsigned 2^(WIDTH-1).
  assign w_abs_a  = op_a[WIDTH-1] ? (~op_a + WIDTH'(1)) : op_a;
  assign w_abs_b  = op_b[WIDTH-1] ? (~op_b + WIDTH'(1)) : op_b;
  assign w_result = r_neg ? (~mul_product + PW'(1)) : mul_product;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_neg   <= 1'b0;
      r_done  <= 1'b0;
      r_mul_a <= '0;
      r_mul_b <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (op_valid) begin
            case (op_code)
              OP_MULTU: begin
                r_mul_a <= op_a;
                r_mul_b <= op_b;
                r_neg   <= 1'b0;
                r_cnt   <= CW'(LATENCY - 1);
                r_state <= S_RUN;
              end
              OP_MULT: begin
                r_mul_a <= w_abs_a;
                r_mul_b <= w_abs_b;
                r_neg   <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
                r_cnt   <= CW'(LATENCY - 1);
                r_state <= S_RUN;
              end
              OP_MTHI: r_hi <= op_a;
              OP_MTLO: r_lo <= op_a;
              default: ;
            endcase
          end
        end
        S_RUN: begin
          // The product is trusted only once the ripple path has had LATENCY cycles to settle.
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
          end else begin
            {r_hi, r_lo} <= w_result;
            r_done       <= 1'b1;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign op_ready = (r_state == S_IDLE);
  assign busy     = (r_state == S_RUN);
  assign stall    = rd_req & busy;
  assign done     = r_done;
  assign mul_a    = r_mul_a;
  assign mul_b    = r_mul_b;
  assign hi       = r_hi;
  assign lo       = r_lo;
  assign rd_data  = rd_sel ? r_hi : r_lo;

endmodule

// File: tb/tb_mul_hilo_ctrl.sv
// Self-checking bench for mul_hilo_ctrl: directed vector table, hand-written
// stall/reset sequences, and randomized ops against an arithmetic HI/LO model.
module tb_mul_hilo_ctrl;
  localparam int WIDTH   = 32;
  localparam int LATENCY = 4;

  logic              clk;
  logic              reset;
  logic              op_valid;
  logic [2:0]        op_code;
  logic [WIDTH-1:0]  op_a, op_b;
  logic              op_ready;
  logic [WIDTH-1:0]  mul_a, mul_b;
  logic [2*WIDTH-1:0] mul_product;
  logic              rd_req, rd_sel;
  logic [WIDTH-1:0]  rd_data;
  logic              stall, busy, done;
  logic [WIDTH-1:0]  hi, lo;

  int vectors;
  int miscompares;

  logic [31:0] m_hi, m_lo;

  typedef struct {
    logic [2:0]  code;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[7];

  mul_hilo_ctrl #(.WIDTH(WIDTH), .LATENCY(LATENCY)) dut (
    .clk(clk), .reset(reset),
    .op_valid(op_valid), .op_code(op_code), .op_a(op_a), .op_b(op_b),
    .op_ready(op_ready), .mul_a(mul_a), .mul_b(mul_b), .mul_product(mul_product),
    .rd_req(rd_req), .rd_sel(rd_sel), .rd_data(rd_data),
    .stall(stall), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  // Stand-in for the external unsigned array multiplier.
  assign mul_product = {32'b0, mul_a} * {32'b0, mul_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    if (c == 3'b001) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  function automatic logic [31:0] ref_abs(input logic [2:0] c, input logic [31:0] v);
    if (c == 3'b001 && v[31]) return 32'd0 - v;
    return v;
  endfunction

  task automatic start_op(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    op_valid = 1'b1; op_code = c; op_a = a; op_b = b;
    @(posedge clk); #1;
    op_valid = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic check_mul(input string nm, input logic [2:0] c, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp);
    int n;
    start_op(c, a, b);
    chk({nm, " busy"}, 64'(busy), 64'd1);
    chk({nm, " mul_a"}, 64'(mul_a), 64'(ref_abs(c, a)));
    chk({nm, " mul_b"}, 64'(mul_b), 64'(ref_abs(c, b)));
    wait_done(n);
    chk({nm, " latency"}, 64'(n), 64'(LATENCY));
    chk({nm, " hilo"}, {hi, lo}, exp);
    chk({nm, " ready"}, 64'(op_ready), 64'd1);
    @(posedge clk); #1;
    chk({nm, " done1"}, 64'(done), 64'd0);
    chk({nm, " mul_a hold"}, 64'(mul_a), 64'(ref_abs(c, a)));
    m_hi = exp[63:32];
    m_lo = exp[31:0];
  endtask

  initial begin
    int n;
    logic [2:0]  c;
    logic [31:0] a, b, pre_lo;
    logic [63:0] p;

    vectors = 0; miscompares = 0;
    reset = 1'b1; op_valid = 1'b0; op_code = 3'b0; op_a = '0; op_b = '0;
    rd_req = 1'b0; rd_sel = 1'b0;

    vecs[0] = '{3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1] = '{3'b001, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[2] = '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[3] = '{3'b001, 32'h80000000, 32'h00000001, 32'hFFFFFFFF, 32'h80000000};
    vecs[4] = '{3'b000, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
    vecs[5] = '{3'b001, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFB};
    vecs[6] = '{3'b001, 32'h00000000, 32'hFFFFFFF9, 32'h00000000, 32'h00000000};

    #12;
    chk("rst hilo", {hi, lo}, 64'd0);
    chk("rst mul", {mul_a, mul_b}, 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst done", 64'(done), 64'd0);
    chk("rst ready", 64'(op_ready), 64'd1);
    @(negedge clk); reset = 1'b0;
    m_hi = 0; m_lo = 0;

    for (int i = 0; i < 7; i++) begin
      check_mul($sformatf("vec%0d", i), vecs[i].code, vecs[i].a, vecs[i].b, {vecs[i].hi, vecs[i].lo});
      $display("vec%0d op=%0d a=%h b=%h -> hi=%h lo=%h", i, vecs[i].code, vecs[i].a, vecs[i].b, hi, lo);
    end

    // MTHI then MFHI with no multiply in flight.
    pre_lo = lo;
    start_op(3'b010, 32'h00001234, 32'h0);
    rd_req = 1'b1; rd_sel = 1'b1; #1;
    chk("mthi rd_data", 64'(rd_data), 64'h1234);
    chk("mthi stall", 64'(stall), 64'd0);
    chk("mthi lo", 64'(lo), 64'(pre_lo));
    chk("mthi busy", 64'(busy), 64'd0);
    m_hi = 32'h1234;
    $display("mthi hi=%h lo=%h", hi, lo);

    // Multiply with an MF read waiting and a second op held valid during RUN.
    start_op(3'b000, 32'h00000003, 32'h00000005);
    op_valid = 1'b1; op_code = 3'b011; op_a = 32'h0000ABCD;
    n = 0;
    while (!done && n < 50) begin
      chk("run stall", 64'(stall), 64'd1);
      chk("run lo held", 64'(lo), 64'(m_lo));
      @(posedge clk); #1;
      n++;
    end
    chk("stall cycles", 64'(n), 64'(LATENCY));
    chk("done stall", 64'(stall), 64'd0);
    chk("done rd_data", 64'(rd_data), 64'd0);
    chk("done ready", 64'(op_ready), 64'd1);
    @(posedge clk); #1;
    op_valid = 1'b0;
    chk("b2b lo", 64'(lo), 64'h0000ABCD);
    chk("b2b hi", 64'(hi), 64'd0);
    rd_req = 1'b0;
    m_hi = 0; m_lo = 32'h0000ABCD;
    $display("b2b hi=%h lo=%h", hi, lo);

    // Reset while RUN has cnt == 1.
    start_op(3'b001, 32'hFFFFFFFD, 32'h7);
    repeat (LATENCY - 2) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("abort hilo", {hi, lo}, 64'd0);
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort ready", 64'(op_ready), 64'd1);
    @(negedge clk); reset = 1'b0;
    for (int k = 0; k < LATENCY + 2; k++) begin
      @(posedge clk); #1;
      chk("abort no done", 64'(done), 64'd0);
    end
    chk("abort hilo after", {hi, lo}, 64'd0);
    m_hi = 0; m_lo = 0;
    $display("abort hi=%h lo=%h", hi, lo);

    for (int i = 0; i < 24; i++) begin
      c = 3'($urandom_range(0, 7));
      a = $urandom; b = $urandom;
      if ($urandom_range(0, 3) == 0) a = 32'h80000000;
      if (c <= 3'd1) begin
        p = ref_mul(c, a, b);
        check_mul($sformatf("rnd%0d", i), c, a, b, p);
      end else begin
        start_op(c, a, b);
        if (c == 3'd2) m_hi = a;
        if (c == 3'd3) m_lo = a;
        chk("rnd busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        chk("rnd done", 64'(done), 64'd0);
        chk("rnd hilo", {hi, lo}, {m_hi, m_lo});
      end
      rd_sel = 1'($urandom_range(0, 1)); #1;
      chk("rnd rd_data", 64'(rd_data), 64'(rd_sel ? m_hi : m_lo));
      $display("rnd%0d op=%0d a=%h b=%h -> hi=%h lo=%h", i, c, a, b, hi, lo);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
